mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 92 +++++++++
 tb/tb_mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response handshakes of both ports plus the memory bus pins.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
);
  logic              req0_valid, req0_ready, req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              req1_valid, req1_ready, req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              mem_read_write, mem_write_commit;
  logic [ADDR_W-1:0] mem_addr_data;
  logic [DATA_W-1:0] mem_result;
  logic              busy;
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata, mem_result,
    input  req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_read_write, mem_write_commit, mem_addr_data, busy
  );
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata, mem_result,
    output req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata,
    output mem_read_write, mem_write_commit, mem_addr_data, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the narrow-bus memory between fetch (port 0) and load/store (port 1).
// Define MEM_ARB_RR_EN for round-robin grant; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int HALF = DATA_W / 2;
  typedef enum logic [2:0] {IDLE, RD, WR_ADDR, WR_HI, WR_LO} state_t;
  state_t r_state;
  logic r_port, r_we;
  logic [DATA_W-1:0] r_wdata;
  logic w_ptr, w_gnt, w_acc, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
`ifdef MEM_ARB_RR_EN
  logic r_ptr;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif
  assign w_gnt = (bus.req0_valid & bus.req1_valid) ? w_ptr : bus.req1_valid;
  assign w_acc = (r_state == IDLE) & (bus.req0_valid | bus.req1_valid);
  assign w_we = w_gnt ? bus.req1_we : bus.req0_we;
  assign w_addr = w_gnt ? bus.req1_addr : bus.req0_addr;
  assign w_wdata = w_gnt ? bus.req1_wdata : bus.req0_wdata;
  assign bus.req0_ready = w_acc & ~w_gnt;
  assign bus.req1_ready = w_acc & w_gnt;
  // The address is held in mem_addr_data itself from accept until the commit phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_port <= 1'b0;
      r_we <= 1'b0;
      r_wdata <= '0;
`ifdef MEM_ARB_RR_EN
      r_ptr <= 1'b0;
`endif
      bus.mem_read_write <= 1'b1;
      bus.mem_write_commit <= 1'b0;
      bus.mem_addr_data <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_rdata <= '0;
      bus.rsp1_rdata <= '0;
      bus.busy <= 1'b0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_rdata <= '0;
      bus.rsp1_rdata <= '0;
      case (r_state)
        IDLE: if (w_acc) begin
          r_state <= w_we ? WR_ADDR : RD;
          r_port <= w_gnt;
          r_we <= w_we;
          r_wdata <= w_wdata;
`ifdef MEM_ARB_RR_EN
          r_ptr <= ~w_gnt;
`endif
          bus.mem_read_write <= ~w_we;
          bus.mem_addr_data <= w_addr;
          bus.busy <= 1'b1;
        end
        WR_ADDR: begin
          r_state <= WR_HI;
          bus.mem_write_commit <= 1'b1;
          bus.mem_addr_data <= ADDR_W'({1'b1, r_wdata[DATA_W-1:HALF]});
        end
        WR_HI: begin
          r_state <= WR_LO;
          bus.mem_addr_data <= ADDR_W'({1'b0, r_wdata[HALF-1:0]});
        end
        RD, WR_LO: begin
          r_state <= IDLE;
          bus.mem_read_write <= 1'b1;
          bus.mem_write_commit <= 1'b0;
          bus.mem_addr_data <= '0;
          bus.busy <= 1'b0;
          bus.rsp0_valid <= ~r_port;
          bus.rsp1_valid <= r_port;
          bus.rsp0_rdata <= (r_port | r_we) ? '0 : bus.mem_result;
          bus.rsp1_rdata <= (~r_port | r_we) ? '0 : bus.mem_result;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven check of mem_port_arbiter against a narrow-bus memory model.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif
  typedef struct {
    int r, v0, w0, a0, d0, v1, w1, a1, d1;
    int rdy0, rdy1, rv0, rd0, rv1, rd1, rw, cm, ad, bz;
  } vec_t;
  logic clk, rst;
  logic [11:0] mem [1024];
  logic [9:0] r_lat;
  vec_t tv[$];
  int n_chk, n_pass, lat;
  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(12)) bus ();
  mem_port_arbiter #(.ADDR_W(10), .DATA_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign bus.mem_result = bus.mem_read_write ? mem[bus.mem_addr_data] : 12'h000;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 12'h000;
    end else if (!bus.mem_read_write) begin
      if (!bus.mem_write_commit) r_lat <= bus.mem_addr_data;
      else if (bus.mem_addr_data[6]) mem[r_lat][11:6] <= bus.mem_addr_data[5:0];
      else mem[r_lat][5:0] <= bus.mem_addr_data[5:0];
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic add(input vec_t v);
    tv.push_back(v);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    //   r  v0 w0 a0     d0      v1 w1 a1     d1      rdy0  rdy1 rv0   rd0     rv1 rd1     rw cm ad                 bz
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      1, 1, 'h005, 'hABC,  0,    1,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 0, 'h005,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 1, 'h06A,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 1, 'h03C,             1});
    add('{0, 0, 0, 0,     0,      1, 0, 'h005, 0,      0,    1,   0,    0,      1,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      1, 0, 'h005,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      1,  'hABC,  1, 0, 0,                 0});
    add('{0, 1, 1, 'h3FF, 'h123,  0, 0, 0,     0,      1,    0,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 0, 'h3FF,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 1, 'h044,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 1, 'h023,             1});
    add('{0, 1, 0, 'h3FF, 0,      0, 0, 0,     0,      1,    0,   1,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      1, 0, 'h3FF,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   1,    'h123,  0,  0,      1, 0, 0,                 0});
    add('{1, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      1,    0,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      0,    0,   0,    0,      0,  0,      1, 0, 'h100,             1});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      1-RR, RR,  1,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      0,    0,   0,    0,      0,  0,      1, 0, RR ? 'h200 : 'h100, 1});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      1,    0,   1-RR, 0,      RR, 0,      1, 0, 0,                 0});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      0,    0,   0,    0,      0,  0,      1, 0, 'h100,             1});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      1-RR, RR,  1,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      0,    0,   0,    0,      0,  0,      1, 0, RR ? 'h200 : 'h100, 1});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      1,    0,   1-RR, 0,      RR, 0,      1, 0, 0,                 0});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      0,    0,   0,    0,      0,  0,      1, 0, 'h100,             1});
    add('{0, 1, 0, 'h100, 0,      1, 0, 'h200, 0,      1-RR, RR,  1,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      1, 0, RR ? 'h200 : 'h100, 1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   1-RR, 0,      RR, 0,      1, 0, 0,                 0});
    add('{0, 1, 1, 'h010, 'hFFF,  0, 0, 0,     0,      1,    0,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 0, 'h010,             1});
    add('{1, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 1, 'h07F,             1});
    add('{0, 1, 0, 'h010, 0,      0, 0, 0,     0,      1,    0,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      1, 0, 'h010,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   1,    0,      0,  0,      1, 0, 0,                 0});
    add('{1, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 1, 0, 'h020, 0,      1, 1, 'h030, 'h555,  1,    0,   0,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      1, 1, 'h030, 'h555,  0,    0,   0,    0,      0,  0,      1, 0, 'h020,             1});
    add('{0, 0, 0, 0,     0,      1, 1, 'h030, 'h555,  0,    1,   1,    0,      0,  0,      1, 0, 0,                 0});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 0, 'h030,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 1, 'h055,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      0,  0,      0, 1, 'h015,             1});
    add('{0, 0, 0, 0,     0,      0, 0, 0,     0,      0,    0,   0,    0,      1,  0,      1, 0, 0,                 0});
    @(posedge clk);
    #1;
    chk("reset rw", 32'(bus.mem_read_write), 1);
    chk("reset commit", 32'(bus.mem_write_commit), 0);
    chk("reset addr_data", 32'(bus.mem_addr_data), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset rsp valids", 32'({bus.rsp0_valid, bus.rsp1_valid}), 0);
    chk("reset rdata", 32'({bus.rsp0_rdata, bus.rsp1_rdata}), 0);
    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].r[0];
      bus.req0_valid = tv[i].v0[0];
      bus.req0_we = tv[i].w0[0];
      bus.req0_addr = tv[i].a0[9:0];
      bus.req0_wdata = tv[i].d0[11:0];
      bus.req1_valid = tv[i].v1[0];
      bus.req1_we = tv[i].w1[0];
      bus.req1_addr = tv[i].a1[9:0];
      bus.req1_wdata = tv[i].d1[11:0];
      #1;
      chk($sformatf("row%0d req0_ready", i), 32'(bus.req0_ready), tv[i].rdy0);
      chk($sformatf("row%0d req1_ready", i), 32'(bus.req1_ready), tv[i].rdy1);
      chk($sformatf("row%0d rsp0_valid", i), 32'(bus.rsp0_valid), tv[i].rv0);
      chk($sformatf("row%0d rsp0_rdata", i), 32'(bus.rsp0_rdata), tv[i].rd0);
      chk($sformatf("row%0d rsp1_valid", i), 32'(bus.rsp1_valid), tv[i].rv1);
      chk($sformatf("row%0d rsp1_rdata", i), 32'(bus.rsp1_rdata), tv[i].rd1);
      chk($sformatf("row%0d read_write", i), 32'(bus.mem_read_write), tv[i].rw);
      chk($sformatf("row%0d write_commit", i), 32'(bus.mem_write_commit), tv[i].cm);
      chk($sformatf("row%0d addr_data", i), 32'(bus.mem_addr_data), tv[i].ad);
      chk($sformatf("row%0d busy", i), 32'(bus.busy), tv[i].bz);
    end
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_we = 1'b0;
    bus.req0_addr = 10'h030;
    bus.req1_valid = 1'b0;
    #1;
    chk("readback accept", 32'(bus.req0_ready), 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    lat = 1;
    while (!bus.rsp0_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("readback latency", 32'(lat), 2);
    chk("readback rdata", 32'(bus.rsp0_rdata), 32'h555);
    chk("readback rsp1 quiet", 32'(bus.rsp1_valid), 0);
    @(negedge clk);
    chk("readback pulse width", 32'(bus.rsp0_valid), 0);
    chk("readback idle", 32'(bus.busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
